reg_pipe: RTL and testbench

REG_PIPE -- requirements
Module: reg_pipe

---
 rtl/reg_pipe.sv | 79 +++++++
 tb/tb_reg_pipe.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/reg_pipe.sv
// Bubble-collapsing register pipeline with DEPTH valid/ready stages.
// Flush drops all queued words but leaves the data registers unchanged. Clear also zeroes the data.
module reg_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] d_q [DEPTH];
  logic [DEPTH-1:0] v_q, v_d;
  logic [OCC_W-1:0] occ_q;

  logic [DEPTH-1:0] can_acc;
  logic [DEPTH-1:0] drains;
  logic [DEPTH-1:0] load;

  function automatic logic [OCC_W-1:0] popcnt(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + OCC_W'(v[i]);
    return c;
  endfunction

  // A stage drains when the next one can take its word; the chain runs back from the output.
  always_comb begin
    can_acc = '0;
    drains  = '0;
    drains[DEPTH-1]  = out_ready;
    can_acc[DEPTH-1] = !v_q[DEPTH-1] || out_ready;
    for (int i = DEPTH-2; i >= 0; i--) begin
      drains[i]  = can_acc[i+1];
      can_acc[i] = !v_q[i] || can_acc[i+1];
    end
  end

  assign in_ready = can_acc[0] && !flush && !clr;

  always_comb begin
    load = '0;
    v_d  = '0;
    load[0] = in_valid && in_ready;
    for (int i = 1; i < DEPTH; i++) load[i] = v_q[i-1] && can_acc[i] && !flush && !clr;
    for (int i = 0; i < DEPTH; i++) v_d[i] = load[i] || (v_q[i] && !drains[i]);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
    end else if (flush) begin
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= popcnt(v_d);
      for (int i = 0; i < DEPTH; i++) begin
        if (load[i]) d_q[i] <= (i == 0) ? in_data : d_q[(i == 0) ? 0 : i-1];
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_reg_pipe.sv
// Directed bench for reg_pipe (WIDTH=8, DEPTH=4): reset, streaming, backpressure,
// bubble collapse, flush and clear/flush priority.
module tb_reg_pipe;

  logic       clk;
  logic       clr;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] occupancy;

  int checks = 0;
  int errors = 0;

  reg_pipe #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    clr = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    // Reset
    #1;
    check("rst_in_ready_during_clr", 32'(in_ready), 32'd0);
    tick();
    tick();
    clr = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming 0x01..0x08 with out_ready held high
    out_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      in_valid = (c <= 8);
      in_data  = (c <= 8) ? 8'(c) : 8'h00;
      #1;
      if (c <= 8) check("stream_in_ready", 32'(in_ready), 32'd1);
      check("stream_out_valid", 32'(out_valid), (c >= 5) ? 32'd1 : 32'd0);
      if (c >= 5) check("stream_out_data", 32'(out_data), 32'(c - 4));
      check("stream_occupancy", 32'(occupancy),
            (c <= 8) ? ((c - 1 > 4) ? 32'd4 : 32'(c - 1)) : 32'(13 - c));
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("stream_drained_valid", 32'(out_valid), 32'd0);
    check("stream_drained_occ", 32'(occupancy), 32'd0);

    // Backpressure: offer 0xA1..0xA5 with out_ready low
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hA1 + k);
      #1;
      check("bp_in_ready_fill", 32'(in_ready), 32'd1);
      tick();
    end
    in_data = 8'hA5;
    #1;
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    check("bp_full_occ", 32'(occupancy), 32'd4);
    check("bp_full_out_data", 32'(out_data), 32'hA1);
    check("bp_full_out_valid", 32'(out_valid), 32'd1);
    tick();
    check("bp_stall_out_data", 32'(out_data), 32'hA1);
    check("bp_stall_occ", 32'(occupancy), 32'd4);
    out_ready = 1'b1;
    #1;
    check("bp_full_pop_in_ready", 32'(in_ready), 32'd1);
    for (int j = 0; j < 5; j++) begin
      check("bp_pop_valid", 32'(out_valid), 32'd1);
      check("bp_pop_data", 32'(out_data), 32'(8'hA1 + j));
      tick();
      in_valid = 1'b0;
    end
    check("bp_done_valid", 32'(out_valid), 32'd0);
    check("bp_done_occ", 32'(occupancy), 32'd0);

    // Bubble collapse
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    in_valid = 1'b1; in_data = 8'h66;
    tick();
    in_valid = 1'b0;
    #1;
    check("bub_out_data", 32'(out_data), 32'h55);
    check("bub_occ", 32'(occupancy), 32'd2);
    check("bub_in_ready", 32'(in_ready), 32'd1);
    tick(); tick();
    out_ready = 1'b1;
    #1;
    check("bub_pop1_data", 32'(out_data), 32'h55);
    tick();
    check("bub_pop2_valid", 32'(out_valid), 32'd1);
    check("bub_pop2_data", 32'(out_data), 32'h66);
    tick();
    check("bub_empty_valid", 32'(out_valid), 32'd0);
    check("bub_empty_occ", 32'(occupancy), 32'd0);

    // Flush on a full pipe
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hA1 + k);
      tick();
    end
    check("fl_full_occ", 32'(occupancy), 32'd4);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd0);
    check("fl_xfer_valid", 32'(out_valid), 32'd1);
    check("fl_xfer_data", 32'(out_data), 32'hA1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("fl_after_occ", 32'(occupancy), 32'd0);
    check("fl_after_valid", 32'(out_valid), 32'd0);
    check("fl_after_in_ready", 32'(in_ready), 32'd1);
    check("fl_data_held", 32'(out_data), 32'hA1);

    // Clear and flush together with an offered word
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    check("pri_two_occ", 32'(occupancy), 32'd2);
    clr = 1'b1; flush = 1'b1; in_data = 8'h33;
    #1;
    check("pri_in_ready", 32'(in_ready), 32'd0);
    tick();
    clr = 1'b0; flush = 1'b0; in_valid = 1'b0;
    #1;
    check("pri_occ", 32'(occupancy), 32'd0);
    check("pri_out_data", 32'(out_data), 32'h00);
    check("pri_out_valid", 32'(out_valid), 32'd0);
    check("pri_in_ready_after", 32'(in_ready), 32'd1);

    // A fresh word after clear traverses the pipe normally
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h44;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("post_valid_early", 32'(out_valid), 32'd0);
    tick();
    check("post_valid", 32'(out_valid), 32'd1);
    check("post_data", 32'(out_data), 32'h44);
    tick();
    check("post_empty", 32'(occupancy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
